mdu_hilo: RTL and testbench
===========================

MDU_HILO -- requirements
Module: mdu_hilo

Interface
REQ-001 SHALL have port: clk  input  1  sole clock, all state on rising edge.
REQ-002 SHALL have port: reset  input  1  synchronous, active-high reset.
REQ-003 SHALL have port: op_valid  input  1  operation request from execute stage.
REQ-004 SHALL have port: op  input  4  operation code: NOP, MULT, MULTU, DIV, DIVU, MTHI, MTLO, MFHI, MFLO.
REQ-005 SHALL have ports: src_a  input  32  rs operand; src_b  input  32  rt operand.
REQ-006 SHALL have port: op_ready  output  1  request accepted this cycle.
REQ-007 SHALL have port: rdata  output  32  MFHI/MFLO read data.
REQ-008 SHALL have port: done  output  1  one-cycle pulse when HI/LO update completes.
REQ-009 SHALL have port: flush  input  1  pipeline flush; kills the in-flight op.
REQ-010 SHALL have ports to the external divider: div_start out 1, div_sign out 1, div_a out 32, div_b out 32, div_result in 64 {remainder, quotient}, div_busy in 1.
REQ-011 SHALL have ports: hi  output  32, lo  output  32  architectural HI/LO registers.

Function
REQ-012 States SHALL be IDLE, MUL1, MUL2, DIV_WAIT; op_ready = (state == IDLE) and not flush.
REQ-013 Accept SHALL occur on op_valid & op_ready; ops offered while not ready are held by the requester.
REQ-014 MFHI/MFLO SHALL complete in the accept cycle, with rdata = hi/lo combinationally; rdata SHALL be 0 for all other ops.
REQ-015 MTHI/MTLO SHALL write src_a to hi/lo at the accept edge and pulse done in the accept cycle.
REQ-016 MULT/MULTU SHALL compute the signed or unsigned 32x32->64 product through two pipeline registers (IDLE->MUL1->MUL2->IDLE).
REQ-017 For MULT/MULTU, {hi,lo} SHALL be written at the MUL2 edge, with done high during MUL2; the result is visible 3 cycles after accept.
REQ-018 On DIV/DIVU accept, div_start SHALL be asserted combinationally for one cycle, with div_sign = (op == DIV), div_a = src_a, div_b = src_b, and the next state DIV_WAIT.
REQ-019 In DIV_WAIT, div_busy low SHALL write hi = div_result[63:32] and lo = div_result[31:0], pulse done, and return to IDLE.
REQ-020 div_busy SHALL be ignored in the accept cycle itself, because the divider raises it one cycle after start.
REQ-021 flush SHALL force IDLE at the next edge, suppress any HI/LO write and done in that cycle, and leave the divider running; its next div_start restarts it.
REQ-022 A flush coinciding with the DIV_WAIT completion cycle SHALL discard the result.
REQ-023 A flush coinciding with an offered op SHALL cause no accept.
REQ-024 Only one op SHALL be in flight at a time; there is no back-to-back MULT overlap.

Reset
REQ-025 Reset SHALL set state = IDLE, hi = 0, lo = 0 and clear all pipeline registers; done = 0 and div_start = 0 while reset is high.
REQ-026 Reset during MUL1, MUL2 or DIV_WAIT SHALL abandon the op with no HI/LO write.

Configuration
REQ-027 Macro MDU_DIV0_BYPASS_EN, when defined: DIV/DIVU with src_b == 0 SHALL NOT assert div_start, SHALL write hi = src_a and lo = 32'hFFFFFFFF at the accept edge, and SHALL pulse done in the accept cycle.
REQ-028 Macro MDU_DIV0_BYPASS_EN, when undefined: divide-by-zero SHALL go through the divider unchanged, and HI/LO SHALL take whatever the divider produces.

Structure
REQ-029 Op encodings and the state enum SHALL live in shared package mdu_pkg.
REQ-030 The two-stage multiplier SHALL be sub-module mdu_mult (inputs a, b, sign; 64-bit product; fixed 2-cycle latency; no handshake).
REQ-031 The divider SHALL remain outside this module and be connected at the parent level.

Verification
REQ-032 MULT with src_a = 32'hFFFFFFFE (-2) and src_b = 3: hi = FFFFFFFF and lo = FFFFFFFA in the cycle after done, with done 2 cycles after accept; MULTU with the same operands gives hi = 00000002, lo = FFFFFFFA.
REQ-033 DIV with src_a = -7 and src_b = 2 against a divider model: div_start is a single cycle, and after div_busy falls hi = FFFFFFFF (-1), lo = FFFFFFFD (-3); op_ready is low throughout DIV_WAIT.
REQ-034 MTHI 0x12345678, then MFHI the next cycle: rdata = 0x12345678 in the MFHI accept cycle.
REQ-035 DIVU 100/7 accepted, flush 3 cycles later, then MFLO: lo keeps its prior value, done never pulses, and op_ready is high one cycle after flush.
REQ-036 DIVU 5/0 with MDU_DIV0_BYPASS_EN: no div_start, hi = 5 and lo = FFFFFFFF at the next edge; without the macro, div_start pulses and the divider output is captured.
REQ-037 Reset asserted during MUL1 after MULT 3x4: hi = lo = 0 afterward and no done pulse.

Source files
------------

// File: rtl/mdu_pkg.sv
// Shared definitions for the HI/LO multiply/divide unit: operation codes,
// control-state encoding and the datapath width.
package mdu_pkg;

   localparam int DATA_W = 32;

   typedef enum logic [3:0] {
      OP_NOP   = 4'd0,
      OP_MULT  = 4'd1,
      OP_MULTU = 4'd2,
      OP_DIV   = 4'd3,
      OP_DIVU  = 4'd4,
      OP_MTHI  = 4'd5,
      OP_MTLO  = 4'd6,
      OP_MFHI  = 4'd7,
      OP_MFLO  = 4'd8
   } op_e;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      MUL1     = 2'd1,
      MUL2     = 2'd2,
      DIV_WAIT = 2'd3
   } state_e;

endpackage

// File: rtl/mdu_hilo_if.sv
// Request channel between the execute stage (master) and the HI/LO unit
// (slave): operation offer, acceptance, move-from read data and completion.
interface mdu_hilo_if;
   import mdu_pkg::*;

   logic              op_valid;
   logic [3:0]        op;
   logic [DATA_W-1:0] src_a;
   logic [DATA_W-1:0] src_b;
   logic              op_ready;
   logic [DATA_W-1:0] rdata;
   logic              done;

   modport master (
      output op_valid, op, src_a, src_b,
      input  op_ready, rdata, done
   );

   modport slave (
      input  op_valid, op, src_a, src_b,
      output op_ready, rdata, done
   );

endinterface

// File: rtl/mdu_mult.sv
// Two-stage 32x32->64 multiplier, signed or unsigned, fixed 2-cycle latency.
// Operands are widened to 64 bits up front so one signed multiply serves
// both modes and the product needs no truncation.
module mdu_mult
   import mdu_pkg::*;
(
   input  logic                clk,
   input  logic                reset,
   input  logic [DATA_W-1:0]   a,
   input  logic [DATA_W-1:0]   b,
   input  logic                sign,
   output logic [2*DATA_W-1:0] product
);

   function automatic logic signed [2*DATA_W-1:0] extend(input logic [DATA_W-1:0] v,
                                                         input logic s);
      return {{DATA_W{s & v[DATA_W-1]}}, v};
   endfunction

   logic signed [2*DATA_W-1:0] a_p0;
   logic signed [2*DATA_W-1:0] b_p0;
   logic signed [2*DATA_W-1:0] prod_p1;

   // Stage 0: capture operands, sign- or zero-extended by mode
   always_ff @(posedge clk) begin
      if (reset) begin
         a_p0 <= '0;
         b_p0 <= '0;
      end else begin
         a_p0 <= extend(a, sign);
         b_p0 <= extend(b, sign);
      end
   end

   // Stage 1: register the full-width product
   always_ff @(posedge clk) begin
      if (reset) begin
         prod_p1 <= '0;
      end else begin
         prod_p1 <= a_p0 * b_p0;
      end
   end

   assign product = prod_p1;

endmodule

// File: rtl/mdu_hilo.sv
// HI/LO multiply/divide unit. Owns the architectural HI/LO registers,
// sequences MULT/MULTU through the two-stage multiplier and DIV/DIVU through
// an external divider, and serves MTHI/MTLO/MFHI/MFLO in the accept cycle.
// Optional build macro MDU_DIV0_BYPASS_EN: divide-by-zero is resolved locally
// (hi = dividend, lo = all ones) without starting the divider.
module mdu_hilo
   import mdu_pkg::*;
(
   input  logic                clk,
   input  logic                reset,
   mdu_hilo_if.slave           bus,
   input  logic                flush,
   output logic                div_start,
   output logic                div_sign,
   output logic [DATA_W-1:0]   div_a,
   output logic [DATA_W-1:0]   div_b,
   input  logic [2*DATA_W-1:0] div_result,
   input  logic                div_busy,
   output logic [DATA_W-1:0]   hi,
   output logic [DATA_W-1:0]   lo
);

   state_e              state;
   state_e              state_next;
   op_e                 op_code;
   logic                op_ready;
   logic                accept;
   logic                div0;
   logic                mul_sign;
   logic                done;
   logic                hi_we;
   logic                lo_we;
   logic [DATA_W-1:0]   hi_next;
   logic [DATA_W-1:0]   lo_next;
   logic [DATA_W-1:0]   rdata;
   logic [2*DATA_W-1:0] product;

   assign op_code  = op_e'(bus.op);
   assign op_ready = (state == IDLE) && !flush;
   assign accept   = bus.op_valid && op_ready && !reset;
   assign mul_sign = (op_code == OP_MULT);

   // The divider samples operands only when div_start is high
   assign div_sign = (op_code == OP_DIV);
   assign div_a    = bus.src_a;
   assign div_b    = bus.src_b;

   assign bus.op_ready = op_ready;
   assign bus.rdata    = rdata;
   assign bus.done     = done;

`ifdef MDU_DIV0_BYPASS_EN
   assign div0 = (bus.src_b == '0);
`else
   assign div0 = 1'b0;
`endif

   mdu_mult u_mult (
      .clk     (clk),
      .reset   (reset),
      .a       (bus.src_a),
      .b       (bus.src_b),
      .sign    (mul_sign),
      .product (product)
   );

   // Next state, HI/LO write enables, done pulse and divider start
   always_comb begin
      state_next = state;
      done       = 1'b0;
      div_start  = 1'b0;
      rdata      = '0;
      hi_we      = 1'b0;
      lo_we      = 1'b0;
      hi_next    = hi;
      lo_next    = lo;
      case (state)
         IDLE: begin
            if (accept) begin
               case (op_code)
                  OP_MULT, OP_MULTU: state_next = MUL1;
                  OP_DIV, OP_DIVU: begin
                     if (div0) begin
                        hi_we   = 1'b1;
                        lo_we   = 1'b1;
                        hi_next = bus.src_a;
                        lo_next = '1;
                        done    = 1'b1;
                     end else begin
                        div_start  = 1'b1;
                        state_next = DIV_WAIT;
                     end
                  end
                  OP_MTHI: begin
                     hi_we   = 1'b1;
                     hi_next = bus.src_a;
                     done    = 1'b1;
                  end
                  OP_MTLO: begin
                     lo_we   = 1'b1;
                     lo_next = bus.src_a;
                     done    = 1'b1;
                  end
                  OP_MFHI: rdata = hi;
                  OP_MFLO: rdata = lo;
                  default: ;
               endcase
            end
         end
         MUL1: state_next = MUL2;
         MUL2: begin
            state_next = IDLE;
            hi_we      = 1'b1;
            lo_we      = 1'b1;
            hi_next    = product[2*DATA_W-1:DATA_W];
            lo_next    = product[DATA_W-1:0];
            done       = 1'b1;
         end
         DIV_WAIT: begin
            // Busy is already high in the first wait cycle, so low means finished
            if (!div_busy) begin
               state_next = IDLE;
               hi_we      = 1'b1;
               lo_we      = 1'b1;
               hi_next    = div_result[2*DATA_W-1:DATA_W];
               lo_next    = div_result[DATA_W-1:0];
               done       = 1'b1;
            end
         end
         default: state_next = IDLE;
      endcase
      // A flush kills whatever is in flight; the divider is simply left running
      if (flush) begin
         state_next = IDLE;
         done       = 1'b0;
         hi_we      = 1'b0;
         lo_we      = 1'b0;
      end
      if (reset) begin
         done      = 1'b0;
         div_start = 1'b0;
         hi_we     = 1'b0;
         lo_we     = 1'b0;
      end
   end

   // State register and architectural HI/LO
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
         hi    <= '0;
         lo    <= '0;
      end else begin
         state <= state_next;
         if (hi_we) hi <= hi_next;
         if (lo_we) lo <= lo_next;
      end
   end

endmodule

// File: tb/tb_mdu_hilo.sv
// Bench for mdu_hilo: directed scenarios plus a randomized operation stream,
// checked against arithmetic reference functions and a HI/LO shadow model.
// An external divider model with programmable latency drives div_busy.
module tb_mdu_hilo;
   import mdu_pkg::*;

   logic        clk = 1'b0;
   logic        reset;
   logic        flush;
   logic        div_start;
   logic        div_sign;
   logic [31:0] div_a;
   logic [31:0] div_b;
   logic [63:0] div_result = '0;
   logic        div_busy = 1'b0;
   logic [31:0] hi;
   logic [31:0] lo;

   int checks = 0;
   int errors = 0;

   mdu_hilo_if bus ();

   mdu_hilo dut (
      .clk        (clk),
      .reset      (reset),
      .bus        (bus),
      .flush      (flush),
      .div_start  (div_start),
      .div_sign   (div_sign),
      .div_a      (div_a),
      .div_b      (div_b),
      .div_result (div_result),
      .div_busy   (div_busy),
      .hi         (hi),
      .lo         (lo)
   );

   always #5 clk = ~clk;

   // Reference arithmetic
   function automatic logic [63:0] mul_ref(input logic [31:0] a, input logic [31:0] b, input bit s);
      longint sa, sb;
      if (s) begin
         sa = longint'(signed'(a));
         sb = longint'(signed'(b));
         return 64'(sa * sb);
      end
      return {32'b0, a} * {32'b0, b};
   endfunction

   // {remainder, quotient}; truncating division, b == 0 gives {a, all ones}
   function automatic logic [63:0] div_ref(input logic [31:0] a, input logic [31:0] b, input bit s);
      longint na, nb, q, r;
      if (b == 32'd0) return {a, 32'hFFFFFFFF};
      if (s) begin
         na = longint'(signed'(a));
         nb = longint'(signed'(b));
      end else begin
         na = longint'({32'b0, a});
         nb = longint'({32'b0, b});
      end
      q = na / nb;
      r = na % nb;
      return {r[31:0], q[31:0]};
   endfunction

   // External divider model: busy rises the cycle after start, falls after div_lat cycles
   int          div_lat = 4;
   int          dv_cnt = 0;
   always @(posedge clk) begin
      if (div_start) begin
         div_busy   <= 1'b1;
         dv_cnt     <= div_lat;
         div_result <= div_ref(div_a, div_b, div_sign);
      end else if (div_busy) begin
         if (dv_cnt <= 1) div_busy <= 1'b0;
         else dv_cnt <= dv_cnt - 1;
      end
   end

   int n_start = 0;
   always @(posedge clk) if (div_start) n_start = n_start + 1;

   // HI/LO shadow model
   logic [31:0] m_hi = '0;
   logic [31:0] m_lo = '0;

   // Accept-cycle observations
   logic        acc_ready, acc_done, acc_start, acc_sign;
   logic [31:0] acc_rdata, acc_a, acc_b;

   // Offer an op in IDLE, record the accept-cycle outputs, return one step after the accept edge
   task automatic drive_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
      bus.op_valid = 1'b1;
      bus.op       = op;
      bus.src_a    = a;
      bus.src_b    = b;
      @(negedge clk);
      acc_ready = bus.op_ready;
      acc_done  = bus.done;
      acc_rdata = bus.rdata;
      acc_start = div_start;
      acc_sign  = div_sign;
      acc_a     = div_a;
      acc_b     = div_b;
      @(posedge clk); #1;
      bus.op_valid = 1'b0;
      bus.op       = OP_NOP;
   endtask

   // n = cycles after the accept cycle at which done is seen (-1 on timeout)
   task automatic wait_done(input int limit, output int n, output bit saw_ready);
      n = -1;
      saw_ready = 1'b0;
      for (int i = 1; i <= limit; i++) begin
         @(negedge clk);
         if (bus.op_ready) saw_ready = 1'b1;
         if (bus.done) begin
            n = i;
            @(posedge clk); #1;
            return;
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      flush = 1'b0;
      bus.op_valid = 1'b1;
      bus.op = OP_MTHI;
      bus.src_a = 32'hDEADBEEF;
      bus.src_b = 32'd3;
      @(negedge clk);
      checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", bus.done); end
      @(posedge clk); #1;
      bus.op = OP_DIV;
      @(negedge clk);
      checks++; if (div_start !== 1'b0) begin errors++; $display("FAIL reset_div_start: got %b expected 0", div_start); end
      @(posedge clk); #1;
      reset = 1'b0;
      bus.op_valid = 1'b0;
      bus.op = OP_NOP;
      @(negedge clk);
      checks++; if (hi !== 32'h0) begin errors++; $display("FAIL reset_hi: got %h expected 00000000", hi); end
      checks++; if (lo !== 32'h0) begin errors++; $display("FAIL reset_lo: got %h expected 00000000", lo); end
      checks++; if (bus.op_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b expected 1", bus.op_ready); end
      @(posedge clk); #1;
   endtask

   task automatic test_mult_vectors();
      int n; bit sr;
      drive_op(OP_MULT, 32'hFFFFFFFE, 32'd3);
      checks++; if (acc_ready !== 1'b1) begin errors++; $display("FAIL mult_accept: got %b expected 1", acc_ready); end
      wait_done(8, n, sr);
      checks++; if (n != 2) begin errors++; $display("FAIL mult_latency: got %0d expected 2", n); end
      checks++; if (sr !== 1'b0) begin errors++; $display("FAIL mult_ready_busy: got %b expected 0", sr); end
      checks++; if (hi !== 32'hFFFFFFFF) begin errors++; $display("FAIL mult_hi: got %h expected ffffffff", hi); end
      checks++; if (lo !== 32'hFFFFFFFA) begin errors++; $display("FAIL mult_lo: got %h expected fffffffa", lo); end
      drive_op(OP_MULTU, 32'hFFFFFFFE, 32'd3);
      wait_done(8, n, sr);
      checks++; if (n != 2) begin errors++; $display("FAIL multu_latency: got %0d expected 2", n); end
      checks++; if (hi !== 32'h00000002) begin errors++; $display("FAIL multu_hi: got %h expected 00000002", hi); end
      checks++; if (lo !== 32'hFFFFFFFA) begin errors++; $display("FAIL multu_lo: got %h expected fffffffa", lo); end
      m_hi = 32'h00000002;
      m_lo = 32'hFFFFFFFA;
   endtask

   task automatic test_div_signed();
      int n; bit sr;
      div_lat = 5;
      n_start = 0;
      drive_op(OP_DIV, 32'hFFFFFFF9, 32'd2);
      checks++; if (acc_start !== 1'b1) begin errors++; $display("FAIL div_start: got %b expected 1", acc_start); end
      checks++; if (acc_sign !== 1'b1) begin errors++; $display("FAIL div_sign: got %b expected 1", acc_sign); end
      checks++; if (acc_a !== 32'hFFFFFFF9 || acc_b !== 32'd2) begin errors++; $display("FAIL div_operands: got %h/%h expected fffffff9/00000002", acc_a, acc_b); end
      wait_done(20, n, sr);
      checks++; if (n != 6) begin errors++; $display("FAIL div_latency: got %0d expected 6", n); end
      checks++; if (sr !== 1'b0) begin errors++; $display("FAIL div_ready_wait: got %b expected 0", sr); end
      checks++; if (n_start != 1) begin errors++; $display("FAIL div_start_count: got %0d expected 1", n_start); end
      checks++; if (hi !== 32'hFFFFFFFF) begin errors++; $display("FAIL div_hi: got %h expected ffffffff", hi); end
      checks++; if (lo !== 32'hFFFFFFFD) begin errors++; $display("FAIL div_lo: got %h expected fffffffd", lo); end
      m_hi = 32'hFFFFFFFF;
      m_lo = 32'hFFFFFFFD;
   endtask

   task automatic test_mthi_mfhi();
      logic [31:0] v;
      drive_op(OP_MTHI, 32'h12345678, $urandom);
      checks++; if (acc_done !== 1'b1) begin errors++; $display("FAIL mthi_done: got %b expected 1", acc_done); end
      checks++; if (acc_rdata !== 32'h0) begin errors++; $display("FAIL mthi_rdata: got %h expected 00000000", acc_rdata); end
      m_hi = 32'h12345678;
      drive_op(OP_MFHI, $urandom, $urandom);
      checks++; if (acc_rdata !== 32'h12345678) begin errors++; $display("FAIL mfhi_rdata: got %h expected 12345678", acc_rdata); end
      checks++; if (acc_done !== 1'b0) begin errors++; $display("FAIL mfhi_done: got %b expected 0", acc_done); end
      v = $urandom;
      drive_op(OP_MTLO, v, $urandom);
      m_lo = v;
      drive_op(OP_MFLO, $urandom, $urandom);
      checks++; if (acc_rdata !== v) begin errors++; $display("FAIL mflo_rdata: got %h expected %h", acc_rdata, v); end
   endtask

   task automatic test_flush_div();
      int pulses;
      logic [31:0] v;
      v = $urandom;
      drive_op(OP_MTLO, v, 32'd0);
      m_lo = v;
      div_lat = 10;
      pulses = 0;
      drive_op(OP_DIVU, 32'd100, 32'd7);
      for (int c = 1; c <= 2; c++) begin
         @(negedge clk); if (bus.done) pulses++;
         @(posedge clk); #1;
      end
      flush = 1'b1;
      @(negedge clk);
      if (bus.done) pulses++;
      checks++; if (bus.op_ready !== 1'b0) begin errors++; $display("FAIL flush_ready_low: got %b expected 0", bus.op_ready); end
      @(posedge clk); #1;
      flush = 1'b0;
      @(negedge clk);
      checks++; if (bus.op_ready !== 1'b1) begin errors++; $display("FAIL flush_ready_after: got %b expected 1", bus.op_ready); end
      for (int c = 0; c < 15; c++) begin
         @(negedge clk); if (bus.done) pulses++;
         @(posedge clk); #1;
      end
      checks++; if (pulses != 0) begin errors++; $display("FAIL flush_no_done: got %0d pulses expected 0", pulses); end
      drive_op(OP_MFLO, 32'd0, 32'd0);
      checks++; if (acc_rdata !== m_lo) begin errors++; $display("FAIL flush_lo_kept: got %h expected %h", acc_rdata, m_lo); end
      checks++; if (hi !== m_hi) begin errors++; $display("FAIL flush_hi_kept: got %h expected %h", hi, m_hi); end
   endtask

   task automatic test_div_flush_complete();
      div_lat = 3;
      drive_op(OP_DIV, $urandom, 32'd9);
      for (int c = 0; c < 3; c++) begin
         @(posedge clk); #1;
      end
      flush = 1'b1;
      @(negedge clk);
      checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL divflush_done: got %b expected 0", bus.done); end
      @(posedge clk); #1;
      flush = 1'b0;
      @(negedge clk);
      checks++; if (hi !== m_hi || lo !== m_lo) begin errors++; $display("FAIL divflush_hilo: got %h_%h expected %h_%h", hi, lo, m_hi, m_lo); end
      checks++; if (bus.op_ready !== 1'b1) begin errors++; $display("FAIL divflush_ready: got %b expected 1", bus.op_ready); end
      @(posedge clk); #1;
   endtask

   task automatic test_flush_mul();
      drive_op(OP_MULT, $urandom, $urandom);
      @(posedge clk); #1;
      flush = 1'b1;
      @(negedge clk);
      checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL mulflush_done: got %b expected 0", bus.done); end
      @(posedge clk); #1;
      flush = 1'b0;
      @(negedge clk);
      checks++; if (hi !== m_hi || lo !== m_lo) begin errors++; $display("FAIL mulflush_hilo: got %h_%h expected %h_%h", hi, lo, m_hi, m_lo); end
      @(posedge clk); #1;
      bus.op_valid = 1'b1;
      bus.op = OP_MTHI;
      bus.src_a = ~m_hi;
      flush = 1'b1;
      @(negedge clk);
      checks++; if (bus.op_ready !== 1'b0) begin errors++; $display("FAIL offer_flush_ready: got %b expected 0", bus.op_ready); end
      checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL offer_flush_done: got %b expected 0", bus.done); end
      @(posedge clk); #1;
      flush = 1'b0;
      bus.op_valid = 1'b0;
      bus.op = OP_NOP;
      @(negedge clk);
      checks++; if (hi !== m_hi) begin errors++; $display("FAIL offer_flush_hi: got %h expected %h", hi, m_hi); end
      @(posedge clk); #1;
   endtask

   task automatic test_div0();
      int n; bit sr;
      n_start = 0;
      div_lat = 2;
      drive_op(OP_DIVU, 32'd5, 32'd0);
`ifdef MDU_DIV0_BYPASS_EN
      checks++; if (acc_start !== 1'b0) begin errors++; $display("FAIL div0_start: got %b expected 0", acc_start); end
      checks++; if (acc_done !== 1'b1) begin errors++; $display("FAIL div0_done: got %b expected 1", acc_done); end
      checks++; if (n_start != 0) begin errors++; $display("FAIL div0_start_count: got %0d expected 0", n_start); end
`else
      checks++; if (acc_start !== 1'b1) begin errors++; $display("FAIL div0_start: got %b expected 1", acc_start); end
      wait_done(20, n, sr);
      checks++; if (n != div_lat + 1) begin errors++; $display("FAIL div0_latency: got %0d expected %0d", n, div_lat + 1); end
`endif
      checks++; if (hi !== 32'd5) begin errors++; $display("FAIL div0_hi: got %h expected 00000005", hi); end
      checks++; if (lo !== 32'hFFFFFFFF) begin errors++; $display("FAIL div0_lo: got %h expected ffffffff", lo); end
      m_hi = 32'd5;
      m_lo = 32'hFFFFFFFF;
   endtask

   task automatic test_reset_mid_mult();
      int pulses;
      pulses = 0;
      drive_op(OP_MULT, 32'd3, 32'd4);
      reset = 1'b1;
      for (int c = 0; c < 2; c++) begin
         @(negedge clk); if (bus.done) pulses++;
         @(posedge clk); #1;
      end
      reset = 1'b0;
      m_hi = '0;
      m_lo = '0;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk); if (bus.done) pulses++;
         @(posedge clk); #1;
      end
      checks++; if (pulses != 0) begin errors++; $display("FAIL rstmul_done: got %0d pulses expected 0", pulses); end
      checks++; if (hi !== 32'h0 || lo !== 32'h0) begin errors++; $display("FAIL rstmul_hilo: got %h_%h expected 00000000_00000000", hi, lo); end
   endtask

   task automatic test_back_to_back();
      logic [3:0]  ops [8];
      logic [3:0]  op;
      logic [31:0] a, b;
      logic [63:0] exp;
      int n; bit sr;
      ops = '{OP_MULT, OP_MULTU, OP_DIV, OP_DIVU, OP_MTHI, OP_MTLO, OP_MFHI, OP_MFLO};
      for (int i = 0; i < 40; i++) begin
         op = ops[$urandom_range(0, 7)];
         a = $urandom;
         b = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
         div_lat = $urandom_range(1, 6);
         case (op)
            OP_MULT, OP_MULTU: begin
               exp = mul_ref(a, b, op == OP_MULT);
               drive_op(op, a, b);
               wait_done(8, n, sr);
               checks++; if (n != 2) begin errors++; $display("FAIL rnd_mul_latency[%0d]: got %0d expected 2", i, n); end
               m_hi = exp[63:32];
               m_lo = exp[31:0];
            end
            OP_DIV, OP_DIVU: begin
               exp = div_ref(a, b, op == OP_DIV);
               drive_op(op, a, b);
`ifdef MDU_DIV0_BYPASS_EN
               if (b == 32'd0) begin
                  checks++; if (acc_done !== 1'b1 || acc_start !== 1'b0) begin errors++; $display("FAIL rnd_div0[%0d]: got done=%b start=%b expected done=1 start=0", i, acc_done, acc_start); end
               end else begin
                  wait_done(20, n, sr);
                  checks++; if (n != div_lat + 1) begin errors++; $display("FAIL rnd_div_latency[%0d]: got %0d expected %0d", i, n, div_lat + 1); end
               end
`else
               wait_done(20, n, sr);
               checks++; if (n != div_lat + 1) begin errors++; $display("FAIL rnd_div_latency[%0d]: got %0d expected %0d", i, n, div_lat + 1); end
`endif
               m_hi = exp[63:32];
               m_lo = exp[31:0];
            end
            OP_MTHI, OP_MTLO: begin
               drive_op(op, a, b);
               checks++; if (acc_done !== 1'b1) begin errors++; $display("FAIL rnd_mt_done[%0d]: got %b expected 1", i, acc_done); end
               if (op == OP_MTHI) m_hi = a;
               else m_lo = a;
            end
            default: begin
               drive_op(op, a, b);
               checks++; if (acc_rdata !== ((op == OP_MFHI) ? m_hi : m_lo)) begin errors++; $display("FAIL rnd_mf_rdata[%0d]: got %h expected %h", i, acc_rdata, (op == OP_MFHI) ? m_hi : m_lo); end
            end
         endcase
         @(negedge clk);
         checks++; if (hi !== m_hi || lo !== m_lo) begin errors++; $display("FAIL rnd_hilo[%0d] op %0d: got %h_%h expected %h_%h", i, op, hi, lo, m_hi, m_lo); end
         @(posedge clk); #1;
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_mult_vectors();
      test_div_signed();
      test_mthi_mfhi();
      test_flush_div();
      test_div_flush_complete();
      test_flush_mul();
      test_div0();
      test_reset_mid_mult();
      test_back_to_back();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
